// File: rtl/loader_pkg.sv
// loader_pkg: shared state encodings and framing constants for the UART RAM loader.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_CNT_HI,
        L_CNT_LO,
        L_DATA_HI,
        L_DATA_LO,
        L_WRITE
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'h55;
    localparam int         BYTES_PER_WORD = 2;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and stop-bit framing check.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK_50,
    input  logic       resetN,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    rx_state_t     state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q    <= RX_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt_q      <= cnt_q - ONE;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= HALF;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= FULL;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= FULL;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        state_q <= (bit_q == 3'd7) ? RX_STOP : RX_DATA;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        byte_valid <= sync2_q;
                        frame_err  <= !sync2_q;
                        byte_data  <= sync2_q ? shift_q : byte_data;
                        state_q    <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: receives SYNC/count/word frames over UART and writes the words
// sequentially into RAM port B, flagging busy/done/framing errors.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 12,
    parameter int START_ADDRESS = 0
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  uart_rx,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int                    CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [ADDR_WIDTH-1:0] START_A      = ADDR_WIDTH'(START_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] A_ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WW_ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   WW_MAX       = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK_50    (CLK_50),
        .resetN    (resetN),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    loader_state_t                        state_q;
    logic [7:0]                           cnt_hi_q;
    logic [15:0]                          left_q;
    logic [8*(BYTES_PER_WORD-1)-1:0]      hi_q;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q       <= L_IDLE;
            cnt_hi_q      <= '0;
            left_q        <= '0;
            hi_q          <= '0;
            mem_address   <= START_A;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // A broken frame aborts whatever transfer is running; idle just records it
            if (frame_err) begin
                error   <= 1'b1;
                busy    <= 1'b0;
                state_q <= L_IDLE;
            end else begin
                case (state_q)
                    L_IDLE: begin
                        if (byte_valid && enable && byte_data == SYNC_BYTE) begin
                            error         <= 1'b0;
                            busy          <= 1'b1;
                            words_written <= '0;
                            mem_address   <= START_A;
                            state_q       <= L_CNT_HI;
                        end
                    end
                    L_CNT_HI: begin
                        if (byte_valid) begin
                            cnt_hi_q <= byte_data;
                            state_q  <= L_CNT_LO;
                        end
                    end
                    L_CNT_LO: begin
                        if (byte_valid) begin
                            left_q  <= {cnt_hi_q, byte_data};
                            done    <= ({cnt_hi_q, byte_data} == 16'd0);
                            busy    <= ({cnt_hi_q, byte_data} != 16'd0);
                            state_q <= ({cnt_hi_q, byte_data} == 16'd0) ? L_IDLE : L_DATA_HI;
                        end
                    end
                    L_DATA_HI: begin
                        if (byte_valid) begin
                            hi_q    <= byte_data;
                            state_q <= L_DATA_LO;
                        end
                    end
                    L_DATA_LO: begin
                        if (byte_valid) begin
                            mem_wdata <= DATA_WIDTH'({hi_q, byte_data});
                            mem_we    <= 1'b1;
                            state_q   <= L_WRITE;
                        end
                    end
                    L_WRITE: begin
                        mem_address   <= mem_address + A_ONE;
                        words_written <= (words_written == WW_MAX) ? words_written : words_written + WW_ONE;
                        left_q        <= left_q - 16'd1;
                        done          <= (left_q == 16'd1);
                        busy          <= (left_q != 16'd1);
                        state_q       <= (left_q == 16'd1) ? L_IDLE : L_DATA_HI;
                    end
                    default: state_q <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: drives UART frames into two loaders (start 0 and start 4094) and
// checks them against a byte-level model of the framing protocol.
module tb_uart_ram_loader;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic en    = 1'b1;

    logic [11:0] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [12:0] ww_a, ww_b;

    always #10 clk = ~clk;

    uart_ram_loader #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .START_ADDRESS(0)) dut_a (
        .CLK_50(clk), .resetN(rst_n), .uart_rx(rx), .enable(en),
        .mem_address(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .busy(busy_a),
        .done(done_a), .error(err_a), .words_written(ww_a)
    );

    uart_ram_loader #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .START_ADDRESS(4094)) dut_b (
        .CLK_50(clk), .resetN(rst_n), .uart_rx(rx), .enable(en),
        .mem_address(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .busy(busy_b),
        .done(done_b), .error(err_b), .words_written(ww_b)
    );

    int          cyc;
    logic [11:0] ga_addr[$], gb_addr[$];
    logic [15:0] ga_data[$], gb_data[$];
    int          done_na, done_nb, last_done_a, bad_a, bad_b;

    always @(posedge clk) begin
        cyc++;
        if (we_a) begin
            ga_addr.push_back(addr_a);
            ga_data.push_back(wdata_a);
        end
        if (we_b) begin
            gb_addr.push_back(addr_b);
            gb_data.push_back(wdata_b);
        end
        if (done_a) begin
            done_na++;
            last_done_a = cyc;
        end
        if (done_b) done_nb++;
        if ((done_a && busy_a) || (we_a && !busy_a)) bad_a++;
        if ((done_b && busy_b) || (we_b && !busy_b)) bad_b++;
    end

    int          n_chk, n_fail, stop_cyc;
    int          m_phase, m_cnt, m_left, m_off, m_ww, m_done;
    logic        m_err, m_busy;
    logic [7:0]  m_hi;
    logic [15:0] m_last;
    int          e_off[$];
    logic [15:0] e_data[$];
    int          seen[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_phase = 0; m_err = 0; m_busy = 0; m_ww = 0; m_off = 0; m_last = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_err = 1;
            if (m_phase != 0) begin
                m_phase = 0;
                m_busy  = 0;
            end
        end else begin
            case (m_phase)
                0: if (en && b == 8'h55) begin
                    m_err = 0; m_busy = 1; m_ww = 0; m_off = 0; m_phase = 1;
                end
                1: begin m_cnt = b; m_phase = 2; end
                2: begin
                    m_left = m_cnt * 256 + b;
                    if (m_left == 0) begin m_done++; m_busy = 0; m_phase = 0; end
                    else m_phase = 3;
                end
                3: begin m_hi = b; m_phase = 4; end
                default: begin
                    m_last = {m_hi, b};
                    e_off.push_back(m_off);
                    e_data.push_back(m_last);
                    m_off++;
                    if (m_ww < 4096) m_ww++;
                    m_left--;
                    if (m_left == 0) begin m_done++; m_busy = 0; m_phase = 0; end
                    else m_phase = 3;
                end
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        stop_cyc = cyc;
        rx = good;
        tick(CPB);
        if (!good) begin
            rx = 1'b1;
            tick(CPB);
        end
        model_byte(b, good);
    endtask

    task automatic check_all(input string tag);
        tick(4);
        for (int d = 0; d < 2; d++) begin
            int    start = d ? 4094 : 0;
            int    nw    = d ? gb_addr.size() : ga_addr.size();
            string t     = $sformatf("%s/%s", tag, d ? "B" : "A");
            chk({t, " nwrites"}, nw, e_off.size());
            for (int i = seen[d]; i < nw && i < e_off.size(); i++) begin
                chk({t, " waddr"}, d ? gb_addr[i] : ga_addr[i], (start + e_off[i]) % 4096);
                chk({t, " wdata"}, d ? gb_data[i] : ga_data[i], e_data[i]);
            end
            seen[d] = nw;
            chk({t, " done"}, d ? done_nb : done_na, m_done);
            chk({t, " error"}, d ? err_b : err_a, m_err);
            chk({t, " busy"}, d ? busy_b : busy_a, m_busy);
            chk({t, " words"}, d ? ww_b : ww_a, m_ww);
            chk({t, " addr"}, d ? addr_b : addr_a, (start + m_off) % 4096);
            chk({t, " wdata_hold"}, d ? wdata_b : wdata_a, m_last);
            chk({t, " we_idle"}, d ? we_b : we_a, 0);
            chk({t, " strobe_rules"}, d ? bad_b : bad_a, 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;
        model_reset();
        tick(3);
        chk("reset addr A", addr_a, 0);
        chk("reset addr B", addr_b, 4094);
        chk("reset outs A", {we_a, busy_a, done_a, err_a, ww_a, wdata_a}, 0);
        chk("reset outs B", {we_b, busy_b, done_b, err_b, ww_b, wdata_b}, 0);
        rst_n = 1'b1;
        tick(10000);
        check_all("idle");

        send_byte(8'h55, 1'b1);
        chk("busy after sync", busy_a, 1);
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(q);
        check_all("two words");

        q = '{8'h55, 8'h00, 8'h00};
        send_frame(q);
        chk("zero-count done latency", (last_done_a - stop_cyc) inside {[CPB/2 : CPB/2 + 6]}, 1);
        check_all("zero count");

        q = '{8'h55, 8'h00, 8'h03, 8'h11, 8'h22};
        send_frame(q);
        send_byte(8'h33, 1'b0);
        check_all("frame error");
        send_byte(8'h55, 1'b1);
        check_all("error cleared");
        q = '{8'h00, 8'h00};
        send_frame(q);
        check_all("after recovery");

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(CPB);
        en = 1'b0;
        q = '{8'hAA, 8'h55};
        send_frame(q);
        check_all("glitch and disabled");
        en = 1'b1;

        q = '{8'h55, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        send_frame(q);
        check_all("wrap");

        for (int k = 0; k < 6; k++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
            n = $urandom_range(0, 4);
            q = '{8'h55, 8'h00, 8'(n)};
            for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
            send_frame(q);
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1'b0);
            check_all($sformatf("random %0d", k));
        end
        en = 1'b1;

        rst_n = 1'b0;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        q = '{8'h55, 8'h00, 8'h02, 8'h12};
        send_frame(q);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset busy", busy_a, 0);
        chk("async reset addr B", addr_b, 4094);
        tick(2);
        rst_n = 1'b1;
        check_all("mid reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Writer-side counterpart to the on-screen memory viewer, which only reads RAM port B.
- Receives a framed byte stream on a UART pin, assembles 16-bit words, and writes them sequentially into RAM port B.
- The screen then shows the loaded data. busy is used at top level to hold the CPU in reset while loading.
- Runs entirely in the CLK_50 domain.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults)
DATA_WIDTH, 16, RAM word width; fixed at 2 bytes per word
ADDR_WIDTH, 12, RAM address width (RAM holds 2**12 words)
START_ADDRESS, 0, first RAM address written by each transfer

Ports:
CLK_50  input  1  system clock
resetN  input  1  asynchronous active-low reset
uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first
enable  input  1  loader accepts a new transfer only while high
mem_address  output  ADDR_WIDTH  RAM port-B write address
mem_wdata  output  DATA_WIDTH  RAM port-B write data
mem_we  output  1  one-cycle write strobe
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the last word has been written
error  output  1  sticky framing-error flag; cleared by the next valid sync byte or by reset
words_written  output  ADDR_WIDTH+1  count of words written in the current or last transfer

Behaviour:
Reset:
- All outputs are 0.
- mem_address = START_ADDRESS.
- uart_rx synchroniser flops are set to 1.
- Both FSMs are in IDLE.

UART receive (sub-module):
- uart_rx passes through a 2-flop synchroniser.
- RX_IDLE: a 1→0 transition on the synchronised line → RX_START and load the bit counter.
- RX_START: sample at CLKS_PER_BIT/2.
  - Line high → treat as a glitch, return to RX_IDLE.
  - Line low → RX_DATA.
- RX_DATA: sample 8 bits at CLKS_PER_BIT spacing, LSB first.
- RX_STOP: sample the stop bit at mid-bit.
  - Stop = 1 → byte_valid pulses for 1 cycle with byte_data.
  - Stop = 0 → frame_err pulses for 1 cycle and no byte is delivered.
- Return to RX_IDLE one cycle after the stop-bit sample. Back-to-back frames are accepted.

Loader FSM (states L_IDLE, L_CNT_HI, L_CNT_LO, L_DATA_HI, L_DATA_LO, L_WRITE):
- Frame format: SYNC = 8'h55, count_hi, count_lo, then count × {word_hi, word_lo}.
- L_IDLE: advances only on byte_valid && enable && byte == SYNC.
  - Other bytes are ignored.
  - On advance: error cleared, busy set, words_written = 0, mem_address = START_ADDRESS.
- L_CNT_HI, then L_CNT_LO: latch the 16-bit count.
  - Count == 0 → pulse done, clear busy, return to L_IDLE.
- L_DATA_HI, then L_DATA_LO: assemble the word, high byte first.
- L_WRITE: lasts exactly 1 cycle.
  - mem_we = 1 with stable mem_address and mem_wdata.
  - Next cycle: mem_address++ (wraps modulo 2**ADDR_WIDTH) and words_written++.
  - Remaining > 0 → L_DATA_HI.
  - Otherwise → done pulses for 1 cycle coincident with busy falling, then L_IDLE.
- Latency: mem_we asserts 1 cycle after the byte_valid of word_lo.
- mem_wdata and mem_address hold their values outside writes.

Boundary and error conditions:
- frame_err in any non-idle state → error = 1, busy = 0, go to L_IDLE. Words already written stay in RAM; no done pulse.
- frame_err in L_IDLE → error = 1, state unchanged.
- Count > 2**ADDR_WIDTH → the address wraps and overwrites. words_written saturates at 2**ADDR_WIDTH.
- enable is sampled only in L_IDLE. Deasserting it mid-transfer has no effect.
- Async reset mid-transfer → immediate return to the reset state. A partial word is discarded.
- byte_valid and frame_err are mutually exclusive by construction.

Decomposition:
- Package loader_pkg holds:
  - the rx_state_t and loader_state_t enums
  - SYNC_BYTE = 8'h55
  - BYTES_PER_WORD = 2
- Sub-module uart_rx:
  - parameters CLKS_PER_BIT
  - ports CLK_50, resetN, rx, byte_valid, byte_data[7:0], frame_err

Test Plan:
- Reset with uart_rx = 1 → all outputs 0, mem_address = 0, no mem_we for 10 000 cycles.
- Send 55 00 02 12 34 AB CD at 115200 baud → exactly two mem_we strobes: (addr 0, 16'h1234) then (addr 1, 16'hABCD); done pulses once; words_written = 2; busy high from the SYNC stop bit to done.
- Send 55 00 00 → done pulses within 2 cycles of the count_lo byte_valid; no mem_we.
- Send 55 00 03 11 22 with the next frame's stop bit forced to 0 → one write (0, 16'h1122); error = 1; busy = 0; no done; a following valid 55 clears error.
- 1 µs low glitch on uart_rx while idle; bytes 0xAA 0x55 sent with enable = 0 → no state change, busy stays 0.
- START_ADDRESS = 4094, count 3 → writes at 4094, 4095, 0; done asserted; words_written = 3.
